// File: rtl/planti_pkg.sv
// Shared types and default timing constants for the plant-watering alarm chain.
package planti_pkg;

    localparam int unsigned CLK_HZ                  = 50_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES     = 1_000_000;      // 20 ms
    localparam int unsigned DEF_CONFIRM_CYCLES      = 250_000_000;    // 5 s
    localparam int unsigned DEF_ALARM_CYCLES        = 343_000_000;    // one melody pass + margin
    localparam int unsigned DEF_COOLDOWN_CYCLES     = 1_500_000_000;  // 30 s
    localparam int          DEF_CNT_W               = 32;

    // Encoding is visible on the estado LEDs, so the codes are fixed.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONFIRM  = 2'd1,
        ST_ALARM    = 2'd2,
        ST_COOLDOWN = 2'd3
    } riego_state_t;

endpackage

// File: rtl/riego_request_ctrl_if.sv
// Sensor/button inputs and alarm request outputs of riego_request_ctrl.
// regar is a level request with no ready: it stays high for the whole alarm window and
// the consumer follows its level; seco/silencio are raw asynchronous levels.
interface riego_request_ctrl_if;
    logic       seco;
    logic       silencio;
    logic       regar;
    logic [1:0] estado;

    modport master (output seco, output silencio, input regar, input estado);
    modport slave  (input seco, input silencio, output regar, output estado);
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stable-time debouncer for one raw input.
module input_debouncer
    import planti_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] cnt;

    // The counter only runs while the synced input disagrees with the filtered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            filt  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                filt <= ~filt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/riego_request_ctrl.sv
// Turns the raw dryness flag and silence button into the level regar request.
// Optional macro SILENCE_LATCH_EN: silencing an alarm mutes re-arming until the soil reads wet.
module riego_request_ctrl
    import planti_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CONFIRM_CYCLES  = DEF_CONFIRM_CYCLES,
    parameter int unsigned ALARM_CYCLES    = DEF_ALARM_CYCLES,
    parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int          CNT_W           = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riego_request_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CONFIRM_LAST  = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALARM_LAST    = CNT_W'(ALARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    logic             dry_f;
    logic             sil_f;
    logic             sil_f_d;
    logic             sil_pulse;
    logic             arm_ok;
    riego_state_t     state;
    riego_state_t     state_nx;
    logic [CNT_W-1:0] cnt;
    logic             regar_q;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dry_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.seco),
        .filt  (dry_f)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sil_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.silencio),
        .filt  (sil_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sil_f_d <= 1'b0;
        else        sil_f_d <= sil_f;
    end

    assign sil_pulse = sil_f & ~sil_f_d;

`ifdef SILENCE_LATCH_EN
    logic muted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             muted <= 1'b0;
        else if (state == ST_ALARM && sil_pulse) muted <= 1'b1;
        else if (!dry_f)                        muted <= 1'b0;
    end

    assign arm_ok = ~muted;
`else
    assign arm_ok = 1'b1;
`endif

    // Dryness clearing during ALARM is deliberately ignored so a melody pass is never cut.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (dry_f && arm_ok) state_nx = ST_CONFIRM;
            ST_CONFIRM: begin
                if (!dry_f)                    state_nx = ST_IDLE;
                else if (cnt == CONFIRM_LAST)  state_nx = ST_ALARM;
            end
            ST_ALARM:    if (sil_pulse || cnt == ALARM_LAST) state_nx = ST_COOLDOWN;
            ST_COOLDOWN: if (cnt == COOLDOWN_LAST)           state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            regar_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= (state_nx != state) ? '0 : cnt + 1'b1;
            regar_q <= (state_nx == ST_ALARM);
        end
    end

    assign bus.regar  = regar_q;
    assign bus.estado = state;

endmodule

// File: tb/tb_riego_request_ctrl.sv
// Directed bench for riego_request_ctrl with a cycle-level reference model of the alarm rules.
module tb_riego_request_ctrl;

    localparam int DB   = 4;
    localparam int CF   = 10;
    localparam int AL   = 20;
    localparam int CD   = 15;
    localparam int HIST = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    riego_request_ctrl_if bus ();

    riego_request_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .CONFIRM_CYCLES  (CF),
        .ALARM_CYCLES    (AL),
        .COOLDOWN_CYCLES (CD),
        .CNT_W           (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 confirm, 2 alarm, 3 cooldown. A phase of length N entered at
    // edge e is left at edge e+N. A filtered input flips once the last DB synced samples
    // (raw input delayed by two edges) all differ from it and DB edges have passed since
    // its previous flip.
    bit raw_h [2][HIST];
    bit syn_h [2][HIST];
    bit m_f   [2];
    int last_flip [2];
    bit m_sil_d;
    bit m_muted;
    int m_state;
    int m_entry;
    int m_edge;
    int m_regar;
    int m_estado;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_f[c]       = 1'b0;
            last_flip[c] = -1;
            for (int i = 0; i < HIST; i++) begin
                raw_h[c][i] = 1'b0;
                syn_h[c][i] = 1'b0;
            end
        end
        m_sil_d  = 1'b0;
        m_muted  = 1'b0;
        m_state  = 0;
        m_entry  = 0;
        m_edge   = 0;
        m_regar  = 0;
        m_estado = 0;
    endfunction

    function automatic void filt_step(input int ch, input bit raw_now, input int k);
        bit s;
        bit flip;
        s = (k >= 2) ? raw_h[ch][(k - 2) % HIST] : 1'b0;
        syn_h[ch][k % HIST] = s;
        raw_h[ch][k % HIST] = raw_now;
        flip = (k - last_flip[ch] >= DB);
        for (int j = 0; j < DB; j++) begin
            if (k - j < 0) flip = 1'b0;
            else if (syn_h[ch][(k - j) % HIST] == m_f[ch]) flip = 1'b0;
        end
        if (flip) begin
            m_f[ch]       = ~m_f[ch];
            last_flip[ch] = k;
        end
    endfunction

    function automatic void model_step(input bit seco_now, input bit sil_now);
        bit fd;
        bit pulse;
        int dwell;
        int nxt;
        fd    = m_f[0];
        pulse = m_f[1] && !m_sil_d;
        dwell = m_edge - m_entry;
        nxt   = m_state;
        case (m_state)
            0: if (fd && !m_muted) nxt = 1;
            1: if (!fd) nxt = 0; else if (dwell == CF) nxt = 2;
            2: if (pulse || dwell == AL) nxt = 3;
            default: if (dwell == CD) nxt = 0;
        endcase
`ifdef SILENCE_LATCH_EN
        if (m_state == 2 && pulse) m_muted = 1'b1;
        else if (!fd)              m_muted = 1'b0;
`endif
        if (nxt != m_state) m_entry = m_edge;
        m_state  = nxt;
        m_regar  = (m_state == 2) ? 1 : 0;
        m_estado = m_state;
        m_sil_d  = m_f[1];
        filt_step(0, seco_now, m_edge);
        filt_step(1, sil_now, m_edge);
        m_edge++;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step(bus.seco, bus.silencio);
        end
    end

    // Every out-of-reset cycle: DUT outputs against the model, half a period after the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cmp_regar", int'(bus.regar), m_regar);
                chk("cmp_estado", int'(bus.estado), m_estado);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_regar(input bit val, input int limit, output int cnt);
        cnt = 0;
        while (bus.regar !== val && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_estado(input int val, input int limit, output int cnt);
        cnt = 0;
        while (int'(bus.estado) != val && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        int c;
        bit saw;
        logic [15:0] pat;

        bus.seco     = 1'b0;
        bus.silencio = 1'b0;
        cyc(3);
        chk("rst_regar", int'(bus.regar), 0);
        chk("rst_estado", int'(bus.estado), 0);
        rst_n = 1'b1;
        cyc(3);

        // Held dryness: edge 0 samples seco, regar rises 16 periods later (17th negedge).
        bus.seco = 1'b1;
        wait_regar(1'b1, 40, c);
        chk("a_rise_latency", c, 17);
        chk("a_estado_alarm", int'(bus.estado), 2);
        wait_regar(1'b0, 40, c);
        chk("a_alarm_len", c, 20);
        chk("a_estado_cool", int'(bus.estado), 3);
        wait_estado(0, 40, c);
        chk("a_cooldown_len", c, 15);
        cyc(1);
        chk("a_reconfirm", int'(bus.estado), 1);
        wait_regar(1'b1, 40, c);
        chk("a_confirm_len", c, 10);

        // Dryness clears 5 cycles into the alarm: the pass still completes.
        cyc(5);
        bus.seco = 1'b0;
        wait_regar(1'b0, 40, c);
        chk("d_alarm_tail", c, 15);
        cyc(30);
        chk("d_settled_idle", int'(bus.estado), 0);

        // Bouncing dryness, no run longer than 3 cycles: filter never changes.
        pat = 16'b1110_1110_0111_0100;
        saw = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            bus.seco = pat[i];
            @(negedge clk);
            if (bus.regar !== 1'b0 || int'(bus.estado) != 0) saw = 1'b1;
        end
        bus.seco = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.regar !== 1'b0 || int'(bus.estado) != 0) saw = 1'b1;
        end
        chk("b_bounce_quiet", int'(saw), 0);

        // Filtered dryness falls at confirm count 7: back to idle, no alarm.
        bus.seco = 1'b1;
        wait_estado(1, 40, c);
        chk("c_confirm_entry", c, 7);
        cyc(1);
        bus.seco = 1'b0;
        saw = 1'b0;
        c = 0;
        while (int'(bus.estado) != 0 && c < 40) begin
            @(negedge clk);
            c++;
            if (bus.regar !== 1'b0) saw = 1'b1;
        end
        chk("c_abort_latency", c, 7);
        chk("c_no_regar", int'(saw), 0);
        cyc(10);

        // Silence held 10 cycles from alarm cycle 8; regar drops the edge after the filtered rise.
        bus.seco = 1'b1;
        wait_regar(1'b1, 40, c);
        chk("e_rise_latency", c, 17);
        cyc(8);
        bus.silencio = 1'b1;
        c = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 10) bus.silencio = 1'b0;
            if (c == 0 && bus.regar === 1'b0) c = i;
        end
        chk("e_silence_fall", c, 7);
        chk("e_estado_cool", int'(bus.estado), 3);
`ifdef SILENCE_LATCH_EN
        wait_regar(1'b1, 40, c);
        chk("e_muted_no_recur", c, 40);
        bus.seco = 1'b0;
        cyc(15);
        bus.seco = 1'b1;
        wait_regar(1'b1, 40, c);
        chk("e_rearm_latency", c, 17);
`else
        wait_regar(1'b1, 40, c);
        chk("e_recur_latency", c, 21);
`endif

        // Reset at alarm cycle 12 drops regar without waiting for a clock edge.
        cyc(11);
        #2 rst_n = 1'b0;
        #1;
        chk("f_async_regar", int'(bus.regar), 0);
        chk("f_async_estado", int'(bus.estado), 0);
        cyc(2);
        rst_n = 1'b1;
        wait_regar(1'b1, 40, c);
        chk("f_full_reconfirm", c, 17);

        bus.seco = 1'b0;
        cyc(60);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
